// File: rtl/systolic_result_serializer_if.sv
// Stream side of the systolic result serializer: one matrix element per
// valid/ready handshake, tagged with its row/column and a last marker.
interface systolic_result_serializer_if #(
    parameter int N     = 4,
    parameter int OUT_W = 16
);
    localparam int RW = $clog2(N);

    logic             o_valid;
    logic             i_ready;
    logic [OUT_W-1:0] o_data;
    logic [RW-1:0]    o_row;
    logic [RW-1:0]    o_col;
    logic             o_last;

    // Serializer side drives the element, consumer drives ready.
    modport master (
        output o_valid,
        input  i_ready,
        output o_data,
        output o_row,
        output o_col,
        output o_last
    );

    modport slave (
        input  o_valid,
        output i_ready,
        input  o_data,
        input  o_row,
        input  o_col,
        input  o_last
    );
endinterface

// File: rtl/systolic_result_serializer.sv
// systolic_result_serializer: captures an N x N x 32-bit result matrix on a
// one-cycle strobe and streams it out row-major, one element per handshake.
// Optional saturation of elements wider than OUT_W is enabled by defining
// SYSTOLIC_RESULT_SAT_EN; otherwise elements are truncated to OUT_W bits.
module systolic_result_serializer #(
    parameter int N     = 4,
    parameter int OUT_W = 16
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic [N-1:0][N-1:0][31:0]   i_c,
    input  logic                        i_validResult,
    output logic                        o_idle,
    output logic                        o_overrun,
    output logic                        o_satSeen,
    systolic_result_serializer_if.master strm
);
    localparam int RW = $clog2(N);
    localparam logic [RW-1:0] MAX_IDX = RW'(N - 1);

    // Parameter sanity: a 1x1 or 2x2 array is not a supported configuration.
    if (N <= 2) begin : g_bad_n
        $error("systolic_result_serializer: N must be > 2");
    end
    if (OUT_W < 1 || OUT_W > 32) begin : g_bad_w
        $error("systolic_result_serializer: OUT_W must be 1..32");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                    state, state_nxt;
    logic [N-1:0][N-1:0][31:0] mat;
    logic [RW-1:0]             row, col;
    logic [RW-1:0]             row_nxt, col_nxt;
    logic [OUT_W-1:0]          data_q, data_nxt;
    logic                      last_q;
    logic                      ovr_q;
    logic                      hs;
    logic                      load_new;
    logic                      advance;
    logic                      go_idle;
    logic [31:0]               elem_nxt;

    assign strm.o_valid = (state == STREAM);
    assign strm.o_data  = data_q;
    assign strm.o_row   = row;
    assign strm.o_col   = col;
    assign strm.o_last  = last_q;
    assign o_idle       = (state == IDLE);
    assign o_overrun    = ovr_q;

    assign hs = strm.o_valid && strm.i_ready;

    // Next state: a strobe is only accepted when idle or on the very
    // handshake that retires the final element, so streams can chain
    // back-to-back without a bubble.
    always_comb begin
        state_nxt = state;
        load_new  = 1'b0;
        advance   = 1'b0;
        go_idle   = 1'b0;
        case (state)
            IDLE: begin
                if (i_validResult) begin
                    load_new  = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (last_q) begin
                        if (i_validResult) begin
                            load_new = 1'b1;
                        end else begin
                            go_idle   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next element position: row-major walk, a fresh matrix starts at [0][0].
    always_comb begin
        row_nxt = '0;
        col_nxt = '0;
        if (advance) begin
            if (col == MAX_IDX) begin
                col_nxt = '0;
                row_nxt = row + RW'(1);
            end else begin
                row_nxt = row;
                col_nxt = col + RW'(1);
            end
        end
    end

    // The first element of a new matrix comes straight from the input bus
    // because the capture buffer is only written at the same edge.
    assign elem_nxt = load_new ? i_c[0][0] : mat[row_nxt][col_nxt];

`ifdef SYSTOLIC_RESULT_SAT_EN
    logic sat_nxt;
    logic sat_q;

    if (OUT_W < 32) begin : g_sat
        // Unsigned clamp: any set bit above OUT_W means the value does not fit.
        always_comb begin
            sat_nxt  = |elem_nxt[31:OUT_W];
            data_nxt = sat_nxt ? {OUT_W{1'b1}} : elem_nxt[OUT_W-1:0];
        end
    end else begin : g_full
        assign sat_nxt  = 1'b0;
        assign data_nxt = elem_nxt[OUT_W-1:0];
    end

    // Sticky flag raised at the edge that presents a clamped element, so it
    // is already high during that element's first valid cycle.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sat_q <= 1'b0;
        end else if ((load_new || advance) && sat_nxt) begin
            sat_q <= 1'b1;
        end
    end

    assign o_satSeen = sat_q;
`else
    if (OUT_W < 32) begin : g_trunc
        logic unused_hi_bits;
        assign unused_hi_bits = ^elem_nxt[31:OUT_W];
    end
    assign data_nxt  = elem_nxt[OUT_W-1:0];
    assign o_satSeen = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture buffer holds the whole result for the duration of the stream.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            mat <= '0;
        end else if (load_new) begin
            mat <= i_c;
        end
    end

    // Output element registers; they only move on a load or a handshake,
    // which keeps them stable while the consumer stalls.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            row    <= '0;
            col    <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (load_new || advance) begin
            row    <= row_nxt;
            col    <= col_nxt;
            data_q <= data_nxt;
            last_q <= (row_nxt == MAX_IDX) && (col_nxt == MAX_IDX);
        end else if (go_idle) begin
            row    <= '0;
            col    <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end
    end

    // Overrun pulse: a strobe that arrived while a stream was still owed
    // elements was dropped.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= i_validResult && (state == STREAM) && !(hs && last_q);
        end
    end
endmodule

// File: tb/tb_systolic_result_serializer.sv
// Self-checking bench for systolic_result_serializer (N=4, OUT_W=16).
// Honours SYSTOLIC_RESULT_SAT_EN for the expected element conversion.
module tb_systolic_result_serializer;
    localparam int N     = 4;
    localparam int OUT_W = 16;
    localparam int RW    = $clog2(N);

    typedef logic [N-1:0][N-1:0][31:0] mat_t;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [RW-1:0]    row;
        logic [RW-1:0]    col;
        logic             last;
        logic             sat;
    } beat_t;

    typedef struct {
        logic [31:0]      elem;
        logic [OUT_W-1:0] exp_data;
        logic             exp_sat;
    } conv_vec_t;

    logic i_clk         = 1'b0;
    logic i_arst_n      = 1'b1;
    mat_t i_c           = '0;
    logic i_validResult = 1'b0;
    logic o_idle;
    logic o_overrun;
    logic o_satSeen;

    systolic_result_serializer_if #(.N(N), .OUT_W(OUT_W)) sif ();

    systolic_result_serializer #(.N(N), .OUT_W(OUT_W)) dut (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_c           (i_c),
        .i_validResult (i_validResult),
        .o_idle        (o_idle),
        .o_overrun     (o_overrun),
        .o_satSeen     (o_satSeen),
        .strm          (sif)
    );

    always #5 i_clk = ~i_clk;

    int    checks = 0;
    int    errors = 0;
    beat_t q[$];
    logic  m_sat = 1'b0;
    logic  m_ovr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion of one 32-bit element into a stream beat.
    function automatic beat_t mk(input logic [31:0] e, input int r, input int c);
        beat_t  b;
        longint maxv;
        maxv   = (longint'(1) << OUT_W) - 1;
        b.row  = RW'(r);
        b.col  = RW'(c);
        b.last = (r == N - 1) && (c == N - 1);
`ifdef SYSTOLIC_RESULT_SAT_EN
        if (longint'(e) > maxv) begin
            b.data = '1;
            b.sat  = 1'b1;
        end else begin
            b.data = e[OUT_W-1:0];
            b.sat  = 1'b0;
        end
`else
        b.data = e[OUT_W-1:0];
        b.sat  = (maxv < 0);
`endif
        return b;
    endfunction

    task automatic push_mat(input mat_t m);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                q.push_back(mk(m[r][c], r, c));
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model.
    task automatic step(input logic rdy, input logic vr);
        beat_t f;
        logic  busy;
        logic  hs;
        sif.i_ready   = rdy;
        i_validResult = vr;
        busy = (q.size() > 0);
        chk("valid", sif.o_valid, busy);
        chk("idle", o_idle, !busy);
        chk("overrun", o_overrun, m_ovr);
        if (busy) begin
            f = q[0];
            if (f.sat) m_sat = 1'b1;
            chk("data", sif.o_data, f.data);
            chk("row", sif.o_row, f.row);
            chk("col", sif.o_col, f.col);
            chk("last", sif.o_last, f.last);
        end
        chk("sat_seen", o_satSeen, m_sat);
        hs    = busy && rdy;
        m_ovr = 1'b0;
        if (hs) void'(q.pop_front());
        if (vr) begin
            if (busy && !(hs && q.size() == 0)) m_ovr = 1'b1;
            else push_mat(i_c);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_arst_n      = 1'b0;
        sif.i_ready   = 1'b0;
        i_validResult = 1'b0;
        #1;
        chk("rst_valid", sif.o_valid, 0);
        chk("rst_idle", o_idle, 1);
        chk("rst_data", sif.o_data, 0);
        chk("rst_row", sif.o_row, 0);
        chk("rst_col", sif.o_col, 0);
        chk("rst_last", sif.o_last, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_sat", o_satSeen, 0);
        q.delete();
        m_sat = 1'b0;
        m_ovr = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_arst_n = 1'b1;
    endtask

    task automatic load_ramp();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                i_c[r][c] = 32'(r * N + c);
    endtask

    // Step with ready high until the model front reaches the given remaining count.
    task automatic run_until(input int remaining, input string name);
        for (int k = 0; k < 200 && q.size() > remaining; k++) step(1'b1, 1'b0);
        chk(name, 64'(q.size()), 64'(remaining));
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200 && q.size() > 0; k++) step(1'b1, 1'b0);
        chk(name, 64'(q.size()), 0);
        step(1'b1, 1'b0);
    endtask

    conv_vec_t vt[5];
    logic      pat[4];

    initial begin
`ifdef SYSTOLIC_RESULT_SAT_EN
        vt[0] = '{32'h0001_2345, 16'hFFFF, 1'b1};
        vt[1] = '{32'h0000_FFFF, 16'hFFFF, 1'b0};
        vt[2] = '{32'h0001_0000, 16'hFFFF, 1'b1};
        vt[3] = '{32'hDEAD_BEEF, 16'hFFFF, 1'b1};
        vt[4] = '{32'h0000_1234, 16'h1234, 1'b0};
`else
        vt[0] = '{32'h0001_2345, 16'h2345, 1'b0};
        vt[1] = '{32'h0000_FFFF, 16'hFFFF, 1'b0};
        vt[2] = '{32'h0001_0000, 16'h0000, 1'b0};
        vt[3] = '{32'hDEAD_BEEF, 16'hBEEF, 1'b0};
        vt[4] = '{32'h0000_1234, 16'h1234, 1'b0};
`endif
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        sif.i_ready = 1'b0;
        #2;
        do_reset();

        // Quiet idle after reset: nothing moves.
        for (int k = 0; k < 20; k++) begin
            step(k[0], 1'b0);
            chk("idle_data", sif.o_data, 0);
        end

        // Ramp matrix, zero-wait drain.
        load_ramp();
        step(1'b1, 1'b1);
        drain("ramp_drain");

        // Ramp matrix with stalling consumer.
        step(1'b1, 1'b1);
        for (int k = 0; k < 100 && q.size() > 0; k++) step(pat[k % 4], 1'b0);
        chk("stall_drain", 64'(q.size()), 0);
        step(1'b1, 1'b0);

        // Dropped strobe mid-stream, then accepted strobe on the last handshake.
        load_ramp();
        step(1'b1, 1'b1);
        run_until(N * N - 4, "ovr_reach");
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                i_c[r][c] = 32'hAA;
        step(1'b1, 1'b1);
        chk("ovr_pulse", o_overrun, 1);
        step(1'b1, 1'b0);
        chk("ovr_once", o_overrun, 0);
        run_until(1, "last_reach");
        step(1'b1, 1'b1);
        chk("chain_data", sif.o_data, 16'hAA);
        drain("chain_drain");

        // Element conversion table: probe placed at [1][2].
        foreach (vt[i]) begin
            do_reset();
            load_ramp();
            i_c[1][2] = vt[i].elem;
            step(1'b1, 1'b1);
            run_until(N * N - 6, "conv_reach");
            chk("conv_data", sif.o_data, vt[i].exp_data);
            drain("conv_drain");
            chk("conv_sat", o_satSeen, vt[i].exp_sat);
        end

        // Reset in the middle of beat 7, then a fresh stream.
        do_reset();
        load_ramp();
        step(1'b1, 1'b1);
        run_until(N * N - 6, "mid_reach");
        do_reset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                i_c[r][c] = $urandom;
        step(1'b1, 1'b1);
        drain("post_rst_drain");

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic vr;
            vr = ($urandom_range(0, 11) == 0);
            if (vr) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        i_c[r][c] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 65535));
            end
            step($urandom_range(0, 3) != 0, vr);
        end
        i_validResult = 1'b0;
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
